multi_digit_display: RTL and testbench
======================================

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digit positions (2..8).
REQ-002 SHALL have parameter WIDTH, default 8: width of the value input (4..16).
REQ-003 SHALL have parameter SIGNED, default 1: 1 = value is two's complement; 0 = value is unsigned.
REQ-004 SHALL have parameter REFRESH_BITS, default 18: each digit is shown for 2^REFRESH_BITS clocks.
REQ-005 SHALL have port clk, input, 1: clock, all state on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port value, input, WIDTH: number to display; sampled only on an accepted load.
REQ-008 SHALL have port load, input, 1: request conversion; accepted only in IDLE.
REQ-009 SHALL have port enable, input, 1: 0 turns all digits off; scanning continues.
REQ-010 SHALL have port busy, output, 1: high in CONVERT and COMMIT.
REQ-011 SHALL have port ready, output, 1: one-cycle pulse after the display registers update.
REQ-012 SHALL have port overflow, output, 1: the last committed value did not fit in N_DIGITS.
REQ-013 SHALL have port anode_n, output, N_DIGITS: active-low digit enables; bit 0 is the rightmost digit.
REQ-014 SHALL have port seg_n, output, 7: active-low segments, order {g,f,e,d,c,b,a}.
REQ-015 SHALL have port dp_n, output, 1: decimal point, held at 1.

Function
REQ-016 SHALL implement a FSM with three states:
  - IDLE: load=1 captures value and goes to CONVERT.
  - CONVERT: exactly WIDTH cycles, then COMMIT.
  - COMMIT: one cycle, then IDLE.
REQ-017 SHALL ignore load while busy=1; the request is dropped, not queued.
REQ-018 SHALL form the magnitude before conversion:
  - SIGNED=1 and value MSB=1: magnitude = two's-complement negation, held WIDTH bits unsigned (e.g. -128 -> 128), negative flag set.
  - Otherwise: magnitude = value, negative flag clear.
REQ-019 SHALL convert magnitude to BCD by iterative shift-add-3, one bit per CONVERT cycle, MSB first.
REQ-020 SHALL use BCD_DIGITS = number of decimal digits of 2^WIDTH-1 (3 for WIDTH=8).
REQ-021 SHALL update the display registers (digit codes, overflow) atomically on the COMMIT->IDLE edge; the displayed value never tears.
REQ-022 SHALL drive ready=1 for exactly the one cycle after the COMMIT->IDLE edge; a load in that cycle is accepted.
REQ-023 SHALL fix latency: load sampled at edge t0 gives busy=1 from t0 to t0+WIDTH+1 and ready=1 in cycle t0+WIDTH+1..t0+WIDTH+2.
REQ-024 SHALL blank leading zeros; magnitude 0 shows a single '0' on digit 0.
REQ-025 SHALL place the minus sign immediately left of the most significant displayed digit.
REQ-026 SHALL flag overflow when significant digits (plus 1 if negative) exceed N_DIGITS: overflow=1 and every digit shows '-' (seg_n=0111111).
REQ-027 SHALL encode digits as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; minus=0111111; blank=1111111.
REQ-028 SHALL scan with a REFRESH_BITS prescaler; on wrap to 0 the digit index advances N_DIGITS-1 -> 0.
REQ-029 SHALL register anode_n and seg_n, reflecting the current index with one cycle of latency.
REQ-030 SHALL drive at most one anode_n bit low in any cycle.
REQ-031 SHALL drive a blank digit with anode_n bit high and seg_n=1111111.
REQ-032 SHALL force anode_n all ones and seg_n=1111111 while enable=0.

Reset
REQ-033 SHALL on rst drive, asynchronously:
  - state IDLE, prescaler 0, index 0;
  - busy=0, ready=0, overflow=0;
  - anode_n all ones, seg_n=1111111, dp_n=1;
  - display registers equal to a committed value of 0.
REQ-034 SHALL on rst mid-conversion abandon the conversion; display returns to '0' and no ready pulse follows.

Verification (N_DIGITS=4, WIDTH=8, SIGNED=1, REFRESH_BITS=2)
REQ-035 SHALL cover load value=-42 (0xD6) -> busy 9 cycles, ready 1 cycle; digit3 blank, digit2 0111111, digit1 0011001, digit0 0100100.
REQ-036 SHALL cover load 0x80 (-128) -> digit3 '-', digit2 1111001, digit1 0100100, digit0 0000000, overflow=0; same value with N_DIGITS=3 -> all digits 0111111, overflow=1.
REQ-037 SHALL cover load 0x00 -> only digit0 anode ever low, seg_n=1000000; anodes 1..3 stay high.
REQ-038 SHALL cover load 7 then load 99 three cycles later -> second load ignored; display shows 7; exactly one ready pulse.
REQ-039 SHALL cover rst asserted in CONVERT cycle 4 -> busy=0 immediately, no ready, display '0'; enable=0 -> anode_n=1111 while the index keeps advancing.

Source files
------------

// File: rtl/multi_digit_display.sv
// Signed/unsigned binary to multiplexed 7-segment display: WIDTH-cycle shift-add-3 conversion,
// atomic commit, ready pulse the cycle after commit; loads while busy are dropped, not queued.
module multi_digit_display #(
    parameter int N_DIGITS     = 4,
    parameter int WIDTH        = 8,
    parameter int SIGNED       = 1,
    parameter int REFRESH_BITS = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    value,
    input  logic                load,
    input  logic                enable,
    output logic                busy,
    output logic                ready,
    output logic                overflow,
    output logic [N_DIGITS-1:0] anode_n,
    output logic [6:0]          seg_n,
    output logic                dp_n
);

    function automatic int dec_digits(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (v > 0) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    localparam int BCD_DIGITS = dec_digits(WIDTH);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int PAD_DIGITS = (N_DIGITS > BCD_DIGITS) ? N_DIGITS : BCD_DIGITS;
    localparam int CNT_W      = $clog2(WIDTH);
    localparam int IDX_W      = $clog2(N_DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        mag_q, mag_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
    logic                    neg_q, neg_d;
    logic                    ready_q;
    logic                    ovf_q, ovf_d;
    logic [6:0]              disp_q [N_DIGITS];
    logic [6:0]              disp_d [N_DIGITS];
    logic [4*PAD_DIGITS-1:0] bcd_pad;
    int                      sig;
    logic [REFRESH_BITS-1:0] presc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [N_DIGITS-1:0]     anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        bcd_adj = bcd_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    neg_d   = (SIGNED != 0) && value[WIDTH-1];
                    mag_d   = neg_d ? (~value + WIDTH'(1)) : value;
                end
            end
            CONVERT: begin
                for (int d = 0; d < BCD_DIGITS; d++) begin
                    if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
                end
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Display image is derived from the finished BCD while in COMMIT and latched in one edge.
    always_comb begin
        bcd_pad = '0;
        bcd_pad[BCD_W-1:0] = bcd_q;
        sig = 1;
        for (int i = 0; i < PAD_DIGITS; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) sig = i + 1;
        end
        ovf_d = (sig + (neg_q ? 1 : 0)) > N_DIGITS;
        for (int i = 0; i < N_DIGITS; i++) begin
            disp_d[i] = SEG_BLANK;
            if (ovf_d)                    disp_d[i] = SEG_MINUS;
            else if (i < sig)             disp_d[i] = seg7(bcd_pad[4*i +: 4]);
            else if (neg_q && (i == sig)) disp_d[i] = SEG_MINUS;
        end
    end

    always_comb begin
        anode_d = '1;
        seg_d   = SEG_BLANK;
        if (enable) begin
            seg_d = disp_q[idx_q];
            if (disp_q[idx_q] != SEG_BLANK) anode_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                disp_q[i] <= (i == 0) ? seg7(4'd0) : SEG_BLANK;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ready_q <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                disp_q <= disp_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    // Scanning free-runs independently of enable and of conversions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_q + REFRESH_BITS'(1);
            if (presc_q == '1) begin
                idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign ready    = ready_q;
    assign overflow = ovf_q;
    assign anode_n  = anode_q;
    assign seg_n    = seg_q;
    assign dp_n     = 1'b1;

endmodule

// File: tb/tb_multi_digit_display.sv
// Bench for multi_digit_display: 4-digit and 3-digit instances share stimulus; scoreboard of
// expected displays is popped by a monitor on every ready pulse.
module tb_multi_digit_display;
    localparam int W  = 8;
    localparam int RB = 2;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst, load, enable;
    logic [7:0] value;
    logic       busy4, ready4, ovf4, dp4;
    logic [3:0] an4;
    logic [6:0] seg4;
    logic       busy3, ready3, ovf3, dp3;
    logic [2:0] an3;
    logic [6:0] seg3;

    multi_digit_display #(.N_DIGITS(4), .WIDTH(W), .SIGNED(1), .REFRESH_BITS(RB)) dut4 (
        .clk(clk), .rst(rst), .value(value), .load(load), .enable(enable),
        .busy(busy4), .ready(ready4), .overflow(ovf4), .anode_n(an4), .seg_n(seg4), .dp_n(dp4));

    multi_digit_display #(.N_DIGITS(3), .WIDTH(W), .SIGNED(1), .REFRESH_BITS(RB)) dut3 (
        .clk(clk), .rst(rst), .value(value), .load(load), .enable(enable),
        .busy(busy3), .ready(ready3), .overflow(ovf3), .anode_n(an3), .seg_n(seg3), .dp_n(dp3));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct packed {
        logic        ovf;
        logic [27:0] codes;
    } exp_t;

    typedef struct {
        exp_t e4;
        exp_t e3;
        int   c0;
        bit   chkd;
    } sb_t;

    sb_t sb[$];
    int  R;

    // Decimal rendering straight from the number: signed value, decimal digits, fit test.
    function automatic exp_t model(input logic [7:0] v, input int nd);
        exp_t r;
        int   mag, m, nsig;
        bit   neg;
        int   d[8];
        neg  = v[7];
        mag  = neg ? 256 - int'(v) : int'(v);
        m    = mag;
        nsig = 0;
        do begin
            d[nsig] = m % 10;
            m       = m / 10;
            nsig++;
        end while (m > 0);
        r.codes = '1;
        r.ovf   = (nsig + int'(neg)) > nd;
        for (int i = 0; i < nd; i++) begin
            if (r.ovf)                   r.codes[i*7 +: 7] = MINUS;
            else if (i < nsig)           r.codes[i*7 +: 7] = SEG[d[i]];
            else if (neg && i == nsig)   r.codes[i*7 +: 7] = MINUS;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Watch one full scan of both displays and rebuild what each digit position shows.
    task automatic capture(output logic [27:0] o4, output logic [27:0] o3, output bit ok);
        int n, pos;
        o4 = '1;
        o3 = '1;
        ok = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            n = 0; pos = 0;
            for (int j = 0; j < 4; j++) if (!an4[j]) begin n++; pos = j; end
            if (n > 1) ok = 1'b0;
            else if (n == 1) o4[pos*7 +: 7] = seg4;
            else if (seg4 != BLANK) ok = 1'b0;
            n = 0; pos = 0;
            for (int j = 0; j < 3; j++) if (!an3[j]) begin n++; pos = j; end
            if (n > 1) ok = 1'b0;
            else if (n == 1) o3[pos*7 +: 7] = seg3;
            else if (seg3 != BLANK) ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [7:0] v, input bit push, input bit chkd);
        sb_t e;
        value = v;
        load  = 1'b1;
        if (push) begin
            e.e4 = model(v, 4);
            e.e3 = model(v, 3);
            e.c0 = cyc + 1;
            e.chkd = chkd;
            sb.push_back(e);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready4) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_timeout", ok, 1);
    endtask

    task automatic run_one(input logic [7:0] v);
        @(negedge clk);
        issue(v, 1, 1);
        wait_ready();
        repeat (30) @(negedge clk);
    endtask

    int          run = 0;
    sb_t         me;
    logic [27:0] m_o4, m_o3;
    bit          m_ok;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (busy4) run++;
            else begin
                if (ready4) begin
                    chk("busy_cycles", run, W + 1);
                    chk("ready_pending", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        me = sb.pop_front();
                        chk("ready_latency", cyc - me.c0, W + 1);
                        chk("ready3_sync", ready3, 1);
                        chk("ovf4", ovf4, me.e4.ovf);
                        chk("ovf3", ovf3, me.e3.ovf);
                        if (me.chkd) begin
                            capture(m_o4, m_o3, m_ok);
                            chk("scan_onehot", m_ok, 1);
                            chk("disp4", m_o4, me.e4.codes);
                            chk("disp3", m_o3, me.e3.codes);
                        end
                    end
                end
                run = 0;
            end
        end
    end

    logic [7:0]  dir_v [9] = '{8'hD6, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h64, 8'h9C, 8'h01, 8'h0A};
    logic [27:0] s_o4, s_o3;
    bit          s_ok;
    exp_t        ex;
    int          idx;
    logic [3:0]  exp_an;

    initial begin : stimulus
        rst = 1'b1; load = 1'b0; enable = 1'b1; value = '0;
        #2;
        chk("rst_busy", busy4, 0);
        chk("rst_ready", ready4, 0);
        chk("rst_ovf", ovf4, 0);
        chk("rst_anode", an4, 4'hF);
        chk("rst_seg", seg4, BLANK);
        chk("rst_dp", dp4, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        R = cyc;
        capture(s_o4, s_o3, s_ok);
        ex = model(8'h00, 4);
        chk("rst_disp4", s_o4, ex.codes);
        ex = model(8'h00, 3);
        chk("rst_disp3", s_o3, ex.codes);

        foreach (dir_v[i]) run_one(dir_v[i]);

        // Second load lands three edges into the first conversion and must vanish.
        @(negedge clk);
        issue(8'd7, 1, 1);
        repeat (2) @(negedge clk);
        issue(8'd99, 0, 0);
        wait_ready();
        repeat (30) @(negedge clk);

        // A load presented during the ready cycle is accepted.
        @(negedge clk);
        issue(8'h2A, 1, 0);
        wait_ready();
        issue(8'hC8, 1, 1);
        wait_ready();
        repeat (30) @(negedge clk);

        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            issue(8'($urandom_range(0, 255)), 1, 1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 7)) @(negedge clk);
                issue(8'($urandom_range(0, 255)), 0, 0);
            end
            wait_ready();
            repeat (30) @(negedge clk);
        end

        // Reset in the fourth conversion cycle.
        @(negedge clk);
        issue(8'h55, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy4, 0);
        chk("midrst_ready", ready4, 0);
        chk("midrst_ovf3", ovf3, 0);
        chk("midrst_anode", an4, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        R = cyc;
        repeat (20) @(negedge clk);
        capture(s_o4, s_o3, s_ok);
        ex = model(8'h00, 4);
        chk("midrst_disp4", s_o4, ex.codes);
        ex = model(8'h00, 3);
        chk("midrst_disp3", s_o3, ex.codes);

        run_one(8'hD6);
        enable = 1'b0;
        s_ok = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (an4 !== 4'hF || seg4 !== BLANK || an3 !== 3'h7 || seg3 !== BLANK) s_ok = 1'b0;
        end
        chk("enable_off", s_ok, 1);
        enable = 1'b1;
        ex = model(8'hD6, 4);
        s_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            idx = ((cyc - R - 1) / (1 << RB)) % 4;
            exp_an = (idx == 3) ? 4'hF : ~(4'b0001 << idx);
            if (an4 !== exp_an || seg4 !== ex.codes[idx*7 +: 7]) s_ok = 1'b0;
        end
        chk("scan_index", s_ok, 1);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
